// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the CPU phase sequencer: FSM states, phase codes and
// helpers that map a state onto its externally visible phase and enables.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_PC   = 3'd1,
    ST_IMEM = 3'd2,
    ST_DMEM = 3'd3,
    ST_REG  = 3'd4
  } seq_state_e;

  localparam logic [1:0] PH_PC   = 2'b00;
  localparam logic [1:0] PH_IMEM = 2'b01;
  localparam logic [1:0] PH_DMEM = 2'b10;
  localparam logic [1:0] PH_REG  = 2'b11;

  function automatic logic [1:0] phase_code(input seq_state_e st);
    logic [1:0] code;
    case (st)
      ST_IMEM: code = PH_IMEM;
      ST_DMEM: code = PH_DMEM;
      ST_REG:  code = PH_REG;
      default: code = PH_PC;
    endcase
    return code;
  endfunction

  // Enable vector ordered {pc, imem, dmem, reg}; all zero in HALT.
  function automatic logic [3:0] enable_vec(input seq_state_e st);
    logic [3:0] en;
    case (st)
      ST_PC:   en = 4'b1000;
      ST_IMEM: en = 4'b0100;
      ST_DMEM: en = 4'b0010;
      ST_REG:  en = 4'b0001;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/cpu_phase_seq_timer.sv
// Phase sub-counter: restarts at zero on phase entry, counts up to CYCLES-1,
// then wraps or holds (saturate) and flags the terminal count now and next.
module phase_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic sat,
  output logic tc,
  output logic tc_next
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, then hold-or-wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (cnt_q == LAST) begin
      if (sat) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = {W{1'b0}};
      end
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc      = (cnt_q == LAST);
  assign tc_next = (cnt_d == LAST);

endmodule

// File: rtl/cpu_phase_seq.sv
// Phase sequencer: walks PC -> IMEM -> DMEM -> REG with registered one-hot
// enables, run/halt/single-step control and a DMEM wait-state handshake.
module cpu_phase_seq
  import cpu_seq_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             imem_en,
  output logic             dmem_en,
  output logic             reg_en,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             halted,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_e       state_q, state_d;
  logic             halt_lat_q, halt_lat_d;
  logic             step_mode_q, step_mode_d;
  logic [3:0]       en_q;
  logic [1:0]       phase_q;
  logic             busy_q, halted_q, done_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_d;
  logic             tc, tc_next, tmr_clr, tmr_sat;

  phase_timer #(.CYCLES(PHASE_CYCLES)) u_timer (
    .clk     (clock),
    .rst_n   (reset),
    .clr     (tmr_clr),
    .sat     (tmr_sat),
    .tc      (tc),
    .tc_next (tc_next)
  );

  // Next-state, latch and retirement logic.
  always_comb begin
    state_d     = state_q;
    halt_lat_d  = halt_lat_q;
    step_mode_d = step_mode_q;
    case (state_q)
      ST_HALT: begin
        if (!halt_req && (run || step)) begin
          state_d     = ST_PC;
          step_mode_d = step;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_PC: begin
        halt_lat_d = halt_lat_q | halt_req;
        state_d    = tc ? ST_IMEM : ST_PC;
      end
      ST_IMEM: begin
        halt_lat_d = halt_lat_q | halt_req;
        state_d    = tc ? ST_DMEM : ST_IMEM;
      end
      ST_DMEM: begin
        halt_lat_d = halt_lat_q | halt_req;
        state_d    = (tc && dmem_ready) ? ST_REG : ST_DMEM;
      end
      ST_REG: begin
        halt_lat_d = halt_lat_q | halt_req;
        if (tc) begin
          // A halt request arriving on the boundary clock still counts.
          if (halt_lat_q || halt_req || step_mode_q || !run) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_PC;
          end
        end else begin
          state_d = ST_REG;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    if (state_d == ST_HALT) begin
      halt_lat_d  = 1'b0;
      step_mode_d = 1'b0;
    end else begin
      halt_lat_d  = halt_lat_d;
      step_mode_d = step_mode_d;
    end
    // Retirement is flagged on the edge that enters the last REG clock.
    done_d  = (state_d == ST_REG) && tc_next;
    count_d = count_q + CNT_W'(done_d);
  end

  assign tmr_clr = (state_d != state_q) || (state_q == ST_HALT);
  assign tmr_sat = (state_q == ST_DMEM);

  // FSM state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HALT;
      halt_lat_q  <= 1'b0;
      step_mode_q <= 1'b0;
      en_q        <= 4'b0000;
      phase_q     <= PH_PC;
      busy_q      <= 1'b0;
      halted_q    <= 1'b1;
      done_q      <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      halt_lat_q  <= halt_lat_d;
      step_mode_q <= step_mode_d;
      en_q        <= enable_vec(state_d);
      phase_q     <= phase_code(state_d);
      busy_q      <= (state_d != ST_HALT);
      halted_q    <= (state_d == ST_HALT);
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign pc_en       = en_q[3];
  assign imem_en     = en_q[2];
  assign dmem_en     = en_q[1];
  assign reg_en      = en_q[0];
  assign phase       = phase_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign instr_done  = done_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Self-checking bench for cpu_phase_seq: directed vector table, hand-written
// corner sequences and randomized traffic against an instruction-level model.
module tb_cpu_phase_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic run, step, hreq, rdy;
  logic run2, step2, hreq2, rdy2;
  logic pc_en, imem_en, dmem_en, reg_en, busy, halted, instr_done;
  logic [1:0] phase;
  logic [31:0] instr_count;
  logic pc_en2, imem_en2, dmem_en2, reg_en2, busy2, halted2, instr_done2;
  logic [1:0] phase2;
  logic [3:0] instr_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_phase_seq #(.PHASE_CYCLES(1), .CNT_W(32)) u_dut (
    .clock(clk), .reset(rst_n), .run(run), .step(step), .halt_req(hreq),
    .dmem_ready(rdy), .pc_en(pc_en), .imem_en(imem_en), .dmem_en(dmem_en),
    .reg_en(reg_en), .phase(phase), .busy(busy), .halted(halted),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  cpu_phase_seq #(.PHASE_CYCLES(2), .CNT_W(4)) u_dut2 (
    .clock(clk), .reset(rst_n), .run(run2), .step(step2), .halt_req(hreq2),
    .dmem_ready(rdy2), .pc_en(pc_en2), .imem_en(imem_en2), .dmem_en(dmem_en2),
    .reg_en(reg_en2), .phase(phase2), .busy(busy2), .halted(halted2),
    .instr_done(instr_done2), .instr_count(instr_count2)
  );

  // Instruction-level model: which phase (0..3) we are in and how long we've been there.
  typedef struct {
    bit          busy;
    int          ph;
    int          el;
    bit          hp;
    bit          single;
    int unsigned cnt;
  } mst_t;

  mst_t m1, m2;

  function automatic mst_t mzero();
    mst_t z;
    z.busy = 0; z.ph = 0; z.el = 0; z.hp = 0; z.single = 0; z.cnt = 0;
    return z;
  endfunction

  function automatic mst_t mstep(mst_t s, int p, bit r, bit st, bit h, bit d);
    mst_t n;
    bit hp_now, adv;
    n = s;
    if (!s.busy) begin
      if (!h && (r || st)) begin
        n.busy = 1; n.ph = 0; n.el = 0; n.single = st; n.hp = 0;
      end
    end else begin
      hp_now = s.hp | h;
      adv = (s.el >= p - 1) && (s.ph != 2 || d);
      if (!adv) begin
        n.el = s.el + 1; n.hp = hp_now;
      end else if (s.ph < 3) begin
        n.ph = s.ph + 1; n.el = 0; n.hp = hp_now;
      end else if (hp_now || s.single || !r) begin
        n.busy = 0; n.ph = 0; n.el = 0; n.hp = 0; n.single = 0;
      end else begin
        n.ph = 0; n.el = 0; n.hp = 0;
      end
    end
    if (n.busy && n.ph == 3 && n.el == p - 1) n.cnt = n.cnt + 1;
    return n;
  endfunction

  // {pc,imem,dmem,reg, phase[1:0], busy, halted, done}
  function automatic logic [8:0] mexp(mst_t s, int p);
    logic [3:0] en;
    logic [1:0] ph;
    en = s.busy ? (4'b1000 >> s.ph) : 4'b0000;
    ph = s.busy ? 2'(s.ph) : 2'b00;
    return {en, ph, s.busy, !s.busy, (s.busy && s.ph == 3 && s.el == p - 1)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m1 = mstep(m1, 1, run, step, hreq, rdy);
    m2 = mstep(m2, 2, run2, step2, hreq2, rdy2);
    #1;
    check("dut1_outputs", {pc_en, imem_en, dmem_en, reg_en, phase, busy, halted, instr_done}, mexp(m1, 1));
    check("dut1_count", instr_count, m1.cnt);
    check("dut1_onehot", 64'($countones({pc_en, imem_en, dmem_en, reg_en}) <= 1), 64'd1);
    check("dut2_outputs", {pc_en2, imem_en2, dmem_en2, reg_en2, phase2, busy2, halted2, instr_done2}, mexp(m2, 2));
    check("dut2_count", instr_count2, m2.cnt % 16);
    check("dut2_onehot", 64'($countones({pc_en2, imem_en2, dmem_en2, reg_en2}) <= 1), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 0; step = 0; hreq = 0; rdy = 1;
    run2 = 0; step2 = 0; hreq2 = 0; rdy2 = 1;
    m1 = mzero(); m2 = mzero();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          r, s, h, d;
    logic [3:0]  en;
    bit          done;
    int unsigned cnt;
  } vec_t;

  vec_t vt[0:26];
  logic [3:0] exp2[0:7];

  initial begin
    vt[0]  = '{1, 0, 0, 1, 4'b1000, 0, 0};
    vt[1]  = '{1, 0, 0, 1, 4'b0100, 0, 0};
    vt[2]  = '{1, 0, 0, 1, 4'b0010, 0, 0};
    vt[3]  = '{1, 0, 0, 1, 4'b0001, 1, 1};
    vt[4]  = '{1, 0, 0, 1, 4'b1000, 0, 1};
    vt[5]  = '{1, 0, 0, 1, 4'b0100, 0, 1};
    vt[6]  = '{1, 0, 0, 0, 4'b0010, 0, 1};
    vt[7]  = '{1, 0, 0, 0, 4'b0010, 0, 1};
    vt[8]  = '{1, 0, 0, 0, 4'b0010, 0, 1};
    vt[9]  = '{0, 0, 0, 0, 4'b0010, 0, 1};
    vt[10] = '{0, 0, 0, 1, 4'b0001, 1, 2};
    vt[11] = '{0, 0, 0, 1, 4'b0000, 0, 2};
    vt[12] = '{0, 1, 0, 1, 4'b1000, 0, 2};
    vt[13] = '{0, 0, 0, 1, 4'b0100, 0, 2};
    vt[14] = '{0, 1, 0, 1, 4'b0010, 0, 2};
    vt[15] = '{0, 0, 0, 1, 4'b0001, 1, 3};
    vt[16] = '{0, 0, 0, 1, 4'b0000, 0, 3};
    vt[17] = '{0, 0, 0, 1, 4'b0000, 0, 3};
    vt[18] = '{1, 0, 1, 1, 4'b0000, 0, 3};
    vt[19] = '{1, 0, 1, 1, 4'b0000, 0, 3};
    vt[20] = '{1, 0, 0, 1, 4'b1000, 0, 3};
    vt[21] = '{1, 0, 0, 1, 4'b0100, 0, 3};
    vt[22] = '{1, 0, 1, 1, 4'b0010, 0, 3};
    vt[23] = '{1, 0, 0, 1, 4'b0001, 1, 4};
    vt[24] = '{1, 0, 1, 1, 4'b0000, 0, 4};
    vt[25] = '{1, 0, 1, 1, 4'b0000, 0, 4};
    vt[26] = '{1, 0, 0, 1, 4'b1000, 0, 4};
    exp2[0] = 4'b1000; exp2[1] = 4'b1000; exp2[2] = 4'b0100; exp2[3] = 4'b0100;
    exp2[4] = 4'b0010; exp2[5] = 4'b0010; exp2[6] = 4'b0001; exp2[7] = 4'b0001;

    do_reset();
    #1;
    check("reset_state", {pc_en, imem_en, dmem_en, reg_en, phase, busy, halted, instr_done}, 9'b0000_00_0_1_0);
    check("reset_count", instr_count, 0);

    // Directed table: start, DMEM stall, run drop, single-step, halt_req.
    for (int i = 0; i < 27; i++) begin
      run = vt[i].r; step = vt[i].s; hreq = vt[i].h; rdy = vt[i].d;
      tick();
      check($sformatf("vec%0d_en", i), {pc_en, imem_en, dmem_en, reg_en}, vt[i].en);
      check($sformatf("vec%0d_done", i), instr_done, vt[i].done);
      check($sformatf("vec%0d_count", i), instr_count, vt[i].cnt);
      check($sformatf("vec%0d_halted", i), halted, (vt[i].en == 4'b0000));
    end

    // Continuous run: 10 instructions in 40 clocks.
    do_reset();
    run = 1; rdy = 1;
    repeat (40) tick();
    check("count_after_40", instr_count, 10);

    // Asynchronous reset between edges while stalled in DMEM.
    do_reset();
    run = 1; rdy = 0;
    repeat (4) tick();
    check("stalled_in_dmem", {pc_en, imem_en, dmem_en, reg_en}, 4'b0010);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {pc_en, imem_en, dmem_en, reg_en, busy, halted, instr_done}, 7'b0000_0_1_0);
    check("async_reset_count", instr_count, 0);
    m1 = mzero(); m2 = mzero();
    @(negedge clk);
    rst_n = 1'b1; run = 1; rdy = 1;
    tick();
    check("restart_at_pc", {pc_en, imem_en, dmem_en, reg_en, phase}, 6'b1000_00);

    // PHASE_CYCLES=2, CNT_W=4: two clocks per enable, wrap after 16 instructions.
    run = 0;
    repeat (6) tick();
    run2 = 1; rdy2 = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("pc2_en%0d", i), {pc_en2, imem_en2, dmem_en2, reg_en2}, exp2[i]);
    end
    check("pc2_done", instr_done2, 1);
    check("pc2_count1", instr_count2, 1);
    repeat (120) tick();
    check("pc2_wrap", instr_count2, 0);
    check("pc2_wrap_done", instr_done2, 1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 2000; i++) begin
      run   = ($urandom_range(0, 9) != 0);
      step  = ($urandom_range(0, 9) == 0);
      hreq  = ($urandom_range(0, 19) == 0);
      rdy   = ($urandom_range(0, 9) < 6);
      run2  = ($urandom_range(0, 7) != 0);
      step2 = ($urandom_range(0, 9) == 0);
      hreq2 = ($urandom_range(0, 19) == 0);
      rdy2  = ($urandom_range(0, 9) < 5);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
